// File: rtl/lv_pwm_intb_decode_pkg.sv
// Shared constants for the LV-side INTB decoder.
// These values must stay in step with the HV encoder parameters.
//   PWM_INTB_EXT_CYC_NUM : cycles per encoded bit on the PWM/INTB line
//   WDG_INTB_TO_TH[cfg]  : LV watchdog timeouts, each >= 2x the matching HV resend period
//   intb_st_e            : decoder FSM states
package lv_pwm_intb_decode_pkg;

  localparam int PWM_INTB_EXT_CYC_NUM = 8;

  // Index [0] is the shortest timeout.
  localparam logic [3:0][15:0] WDG_INTB_TO_TH = {16'd512, 16'd256, 16'd128, 16'd64};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MIS1,
    ST_GAP,
    ST_MIS2,
    ST_ERR
  } intb_st_e;

endpackage

// File: rtl/lv_pwm_intb_decode_run_cnt.sv
// lv_run_len_cnt: saturating run-length counter for the INTB decoder.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : force count to 0
//   i_load         : start a new run (count = 1)
//   i_inc          : extend the current run (saturates at EXT+TOL+1)
//   o_in_range     : EXT-TOL <= count <= EXT+TOL
//   o_too_short    : count < EXT-TOL
//   o_overrun      : count > EXT+TOL
module lv_run_len_cnt #(
  parameter int EXT = 8,
  parameter int TOL = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_inc,
  output logic o_in_range,
  output logic o_too_short,
  output logic o_overrun
);

  localparam int SAT = EXT + TOL + 1;
  localparam int W   = $clog2(SAT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                         cnt <= '0;
    else if (i_clr)                       cnt <= '0;
    else if (i_load)                      cnt <= W'(1);
    else if (i_inc && cnt != W'(SAT))     cnt <= cnt + W'(1);
  end

  assign o_too_short = cnt <  W'(EXT - TOL);
  assign o_overrun   = cnt >  W'(EXT + TOL);
  assign o_in_range  = !o_too_short && !o_overrun;

endmodule

// File: rtl/lv_pwm_intb_decode.sv
// lv_pwm_intb_decode: LV-side receiver for the INTB state carried on the
// returned PWM channel. The line is compared with the delayed local gate-wave;
// mismatch/match run lengths decode intb0 (one inverted bit) and intb1
// (inverted, normal, inverted).
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_pwm_intb_n     : received PWM/INTB line (already synchronised)
//   i_lv_pwm_gwave   : locally driven gate-wave (reference)
//   i_wdgintb_en     : watchdog enable
//   i_wdgintb_config : watchdog timeout select
//   o_lv_intb_n      : decoded interrupt level (0 = active)
//   o_intb_vld       : 1-cycle pulse per decoded frame
//   o_frame_err      : 1-cycle pulse per malformed frame
//   o_wdg_timeout    : sticky, no valid frame within the timeout
module lv_pwm_intb_decode
  import lv_pwm_intb_decode_pkg::*;
#(
  parameter int PWM_INTB_EXT_CYC_NUM_P = PWM_INTB_EXT_CYC_NUM,
  parameter int REF_DLY_CYC            = 2,
  parameter int RUN_TOL                = 1,
  parameter int WDG_CNT_W              = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pwm_intb_n,
  input  logic       i_lv_pwm_gwave,
  input  logic       i_wdgintb_en,
  input  logic [1:0] i_wdgintb_config,
  output logic       o_lv_intb_n,
  output logic       o_intb_vld,
  output logic       o_frame_err,
  output logic       o_wdg_timeout
);

  // Reference delay line: aligns the gate-wave with the round-trip line.
  logic [REF_DLY_CYC-1:0] ref_dly;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) ref_dly <= '0;
    else begin
      ref_dly[0] <= i_lv_pwm_gwave;
      for (int i = 1; i < REF_DLY_CYC; i++) ref_dly[i] <= ref_dly[i-1];
    end
  end

  logic mis;
  assign mis = i_pwm_intb_n ^ ref_dly[REF_DLY_CYC-1];

  // Run counter
  logic run_clr, run_load, run_inc;
  logic in_range, too_short, overrun;

  lv_run_len_cnt #(.EXT(PWM_INTB_EXT_CYC_NUM_P), .TOL(RUN_TOL)) u_run (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (run_clr),
    .i_load      (run_load),
    .i_inc       (run_inc),
    .o_in_range  (in_range),
    .o_too_short (too_short),
    .o_overrun   (overrun)
  );

  // FSM
  intb_st_e st, st_nxt;
  logic     vld_nxt, err_nxt, intb_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) st <= ST_IDLE;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    run_clr  = 1'b0;
    run_load = 1'b0;
    run_inc  = 1'b0;
    vld_nxt  = 1'b0;
    err_nxt  = 1'b0;
    intb_nxt = o_lv_intb_n;
    case (st)
      ST_IDLE: begin
        if (mis) begin st_nxt = ST_MIS1; run_load = 1'b1; end
        else     run_clr = 1'b1;
      end
      ST_MIS1: begin
        if (mis) begin
          if (overrun) begin st_nxt = ST_ERR; err_nxt = 1'b1; end
          else         run_inc = 1'b1;
        end else if (in_range) begin
          st_nxt = ST_GAP; run_load = 1'b1;
        end else begin
          // short run is a glitch; an over-long run that ends here is an error
          st_nxt  = ST_IDLE;
          run_clr = 1'b1;
          err_nxt = !too_short;
        end
      end
      ST_GAP: begin
        // a gap longer than one bit means no second mismatch follows: intb0
        if (overrun) begin
          st_nxt = ST_IDLE; run_clr = 1'b1; vld_nxt = 1'b1; intb_nxt = 1'b0;
        end else if (mis) begin
          if (in_range) begin st_nxt = ST_MIS2; run_load = 1'b1; end
          else          begin st_nxt = ST_ERR;  err_nxt  = 1'b1; end
        end else begin
          run_inc = 1'b1;
        end
      end
      ST_MIS2: begin
        if (mis) begin
          if (overrun) begin st_nxt = ST_ERR; err_nxt = 1'b1; end
          else         run_inc = 1'b1;
        end else begin
          st_nxt  = ST_IDLE;
          run_clr = 1'b1;
          if (in_range) begin vld_nxt = 1'b1; intb_nxt = 1'b1; end
          else          err_nxt = 1'b1;
        end
      end
      ST_ERR: begin
        if (!mis) begin st_nxt = ST_IDLE; run_clr = 1'b1; end
      end
      default: begin st_nxt = ST_IDLE; run_clr = 1'b1; end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_lv_intb_n <= 1'b1;
      o_intb_vld  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_lv_intb_n <= intb_nxt;
      o_intb_vld  <= vld_nxt;
      o_frame_err <= err_nxt;
    end
  end

  // Watchdog: a decoded frame takes priority over reaching the threshold.
  logic [WDG_CNT_W-1:0] wdg_cnt, wdg_inc, wdg_th_m1;
  logic [1:0]           cfg_q;

  assign wdg_inc   = wdg_cnt + WDG_CNT_W'(1);
  assign wdg_th_m1 = WDG_CNT_W'(WDG_INTB_TO_TH[i_wdgintb_config]) - WDG_CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wdg_cnt       <= '0;
      o_wdg_timeout <= 1'b0;
      cfg_q         <= '0;
    end else begin
      cfg_q <= i_wdgintb_config;
      if (!i_wdgintb_en || vld_nxt) begin
        wdg_cnt       <= '0;
        o_wdg_timeout <= 1'b0;
      end else if (i_wdgintb_config != cfg_q) begin
        wdg_cnt <= '0;
      end else if (!o_wdg_timeout) begin
        wdg_cnt <= wdg_inc;
        if (wdg_inc == wdg_th_m1) o_wdg_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lv_pwm_intb_decode.sv
module tb_lv_pwm_intb_decode;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_pwm_intb_n;
  logic       i_lv_pwm_gwave;
  logic       i_wdgintb_en;
  logic [1:0] i_wdgintb_config;
  logic       o_lv_intb_n, o_intb_vld, o_frame_err, o_wdg_timeout;

  lv_pwm_intb_decode dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pwm_intb_n     (i_pwm_intb_n),
    .i_lv_pwm_gwave   (i_lv_pwm_gwave),
    .i_wdgintb_en     (i_wdgintb_en),
    .i_wdgintb_config (i_wdgintb_config),
    .o_lv_intb_n      (o_lv_intb_n),
    .o_intb_vld       (o_intb_vld),
    .o_frame_err      (o_frame_err),
    .o_wdg_timeout    (o_wdg_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit is_err;
    bit intb_n;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // Monitor: every vld/err pulse must match the oldest expected event.
  always @(negedge i_clk) begin
    if (o_intb_vld || o_frame_err) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d vld=%0b err=%0b intb_n=%0b", cyc, o_intb_vld, o_frame_err, o_lv_intb_n);
      end else begin
        e = q.pop_front();
        if (o_frame_err != e.is_err || o_intb_vld == e.is_err || cyc != e.cyc ||
            (!e.is_err && o_lv_intb_n != e.intb_n)) begin
          bad++;
          $display("FAIL event got cyc=%0d vld=%0b err=%0b intb_n=%0b, want cyc=%0d err=%0b intb_n=%0b",
                   cyc, o_intb_vld, o_frame_err, o_lv_intb_n, e.cyc, e.is_err, e.intb_n);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, want, cyc);
    end
  endtask

  // Drive the line at v for n edges; first = cycle of the first sampling edge.
  task automatic run(input bit v, input int n, output int first);
    i_pwm_intb_n = v;
    first = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) first = cyc;
    end
  endtask

  task automatic push(input bit is_err, input bit intb_n, input int c);
    exp_t x;
    x.is_err = is_err;
    x.intb_n = intb_n;
    x.cyc    = c;
    q.push_back(x);
  endtask

  initial begin
    int a, h, f;
    i_rst_n = 1'b0; i_pwm_intb_n = 1'b0; i_lv_pwm_gwave = 1'b0;
    i_wdgintb_en = 1'b0; i_wdgintb_config = 2'd0;
    repeat (3) tick();
    chk("rst_intb_n",  {31'd0, o_lv_intb_n},   32'd1);
    chk("rst_vld",     {31'd0, o_intb_vld},    32'd0);
    chk("rst_err",     {31'd0, o_frame_err},   32'd0);
    chk("rst_timeout", {31'd0, o_wdg_timeout}, 32'd0);
    i_rst_n = 1'b1;
    run(0, 4, a);

    // intb0: high 8, long low -> vld 10 cycles after the fall
    run(1, 8, a); run(0, 1, f); push(0, 0, f + 10); run(0, 14, a);
    chk("intb0_level", {31'd0, o_lv_intb_n}, 32'd0);

    // intb1: 8/8/8 -> vld on the final fall
    run(1, 8, a); run(0, 8, a); run(1, 8, a); run(0, 1, f); push(0, 1, f); run(0, 12, a);
    chk("intb1_level", {31'd0, o_lv_intb_n}, 32'd1);

    // tolerance edges: 7/9/9 intb1, then 9 high intb0
    run(1, 7, a); run(0, 9, a); run(1, 9, a); run(0, 1, f); push(0, 1, f); run(0, 12, a);
    run(1, 9, a); run(0, 1, f); push(0, 0, f + 10); run(0, 14, a);

    // 5-cycle glitch: silently dropped
    run(1, 5, a); run(0, 15, a);
    chk("glitch_level", {31'd0, o_lv_intb_n}, 32'd0);

    // MIS2 overrun: 11th high cycle flags the error, level unchanged
    run(1, 8, a); run(0, 8, a); run(1, 11, h); push(1, 0, h + 10); run(0, 12, a);
    chk("overrun_level", {31'd0, o_lv_intb_n}, 32'd0);

    // reference edge inside MIS2: ref lands on its 4th cycle
    run(1, 8, a); run(0, 8, a);
    i_pwm_intb_n = 1'b1; tick(); h = cyc; push(1, 0, h + 3);
    i_lv_pwm_gwave = 1'b1;
    run(1, 7, a);
    i_lv_pwm_gwave = 1'b0;
    run(0, 12, a);
    chk("refedge_level", {31'd0, o_lv_intb_n}, 32'd0);

    // watchdog cfg=0 (threshold 64): sets after 63 enabled cycles
    i_wdgintb_en = 1'b1;
    tick();
    repeat (61) tick();
    chk("wdg_before_th", {31'd0, o_wdg_timeout}, 32'd0);
    tick();
    chk("wdg_at_th", {31'd0, o_wdg_timeout}, 32'd1);
    repeat (10) tick();
    chk("wdg_sticky", {31'd0, o_wdg_timeout}, 32'd1);
    run(1, 8, a); run(0, 8, a); run(1, 8, a);
    chk("wdg_pre_vld", {31'd0, o_wdg_timeout}, 32'd1);
    run(0, 1, f); push(0, 1, f);
    chk("wdg_clr_vld", {30'd0, o_intb_vld, o_wdg_timeout}, 32'd2);
    run(0, 4, a);
    i_wdgintb_en = 1'b0;
    run(0, 2, a);

    // reset in GAP: partial frame discarded
    run(1, 8, a); run(0, 1, f); push(0, 0, f + 10); run(0, 12, a);
    run(1, 8, a); run(0, 3, a);
    i_rst_n = 1'b0; tick();
    chk("midrst_out", {28'd0, o_lv_intb_n, o_intb_vld, o_frame_err, o_wdg_timeout}, 32'h8);
    i_rst_n = 1'b1;
    run(0, 15, a);
    run(1, 8, a); run(0, 8, a); run(1, 8, a); run(0, 1, f); push(0, 1, f); run(0, 20, a);

    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
